// File: rtl/mext_pkg.sv
// Shared types and constants for the RV32M multiply issue controller.
package mext_pkg;

    // Multiplier operation select, encoded exactly as instruction funct3[1:0]
    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_t;

    // Issue controller states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BUSY  = 3'd1,
        OUT   = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } mext_state_t;

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    // True when opcode/funct7 select the M-extension group (mul and div alike)
    function automatic logic mext_enc(input logic [6:0] opcode, input logic [6:0] funct7);
        return (opcode == OPC_OP) && (funct7 == F7_MEXT);
    endfunction

endpackage

// File: rtl/mext_decode.sv
// Combinational classifier for M-extension R-type instructions sitting in EX.
module mext_decode
    import mext_pkg::*;
(
    input  logic       ex_valid,
    input  logic [6:0] ex_opcode,
    input  logic [2:0] ex_funct3,
    input  logic [6:0] ex_funct7,
    output logic       is_mul,
    output logic       is_div,
    output mul_op_t    mul_op
);

    logic group_s;

    // Split the M group into multiplies (funct3[2]=0) and divides (funct3[2]=1)
    always_comb begin
        group_s = ex_valid && mext_enc(ex_opcode, ex_funct7);
        is_mul  = 1'b0;
        is_div  = 1'b0;
        mul_op  = mul_op_t'(ex_funct3[1:0]);
        if (group_s) begin
            is_mul = !ex_funct3[2];
            is_div = ex_funct3[2];
        end else begin
            is_mul = 1'b0;
            is_div = 1'b0;
        end
    end

endmodule

// File: rtl/mext_issue_ctrl.sv
// EX-stage controller for RV32M multiplies: launches the iterative multiplier,
// stalls the front end while it runs, and hands the result to MEM.
module mext_issue_ctrl
    import mext_pkg::*;
#(
    parameter int TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [6:0]  ex_opcode,
    input  logic [2:0]  ex_funct3,
    input  logic [6:0]  ex_funct7,
    input  logic [31:0] ex_rs1,
    input  logic [31:0] ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        flush,
    input  logic        mem_stall,
    output logic        startM,
    output logic [1:0]  mul_opcode,
    output logic [31:0] operand1,
    output logic [31:0] operand2,
    input  logic [31:0] result_multiply,
    input  logic        done,
    output logic        stall_mext,
    output logic        mext_valid,
    output logic [31:0] mext_result,
    output logic [4:0]  mext_rd,
    output logic        mext_illegal,
    output logic        mext_timeout
);

    // Wide enough to hold TIMEOUT plus one step of headroom
    localparam int               CNT_W      = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(TIMEOUT);

    mext_state_t      state_r;
    logic [CNT_W-1:0] wdog_cnt_r;
    logic [CNT_W-1:0] wdog_inc_s;
    logic             wdog_hit_s;
    logic [4:0]       rd_lat_r;
    logic [31:0]      result_r;
    logic [4:0]       rd_r;
    logic             valid_r;
    logic             illegal_r;
    logic             timeout_r;

    logic             is_mul_s;
    logic             is_div_s;
    mul_op_t          dec_op_s;
    logic             start_s;
    logic             stall_s;

    mext_decode u_decode (
        .ex_valid  (ex_valid),
        .ex_opcode (ex_opcode),
        .ex_funct3 (ex_funct3),
        .ex_funct7 (ex_funct7),
        .is_mul    (is_mul_s),
        .is_div    (is_div_s),
        .mul_op    (dec_op_s)
    );

    // The counter holds the number of cycles since the start pulse; the
    // watchdog fires when the next value would reach TIMEOUT, so the flag and
    // the return to IDLE become visible exactly TIMEOUT cycles after start.
    assign wdog_inc_s = wdog_cnt_r + CNT_ONE;
    assign wdog_hit_s = (wdog_inc_s >= WDOG_LIMIT);

    // Same-cycle launch and stall decisions derived from the registered state
    always_comb begin
        start_s = 1'b0;
        stall_s = 1'b0;
        if (rst) begin
            start_s = 1'b0;
            stall_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    start_s = is_mul_s && !flush;
                    stall_s = is_mul_s && !flush;
                end
                BUSY: begin
                    stall_s = 1'b1;
                end
                OUT: begin
                    stall_s = 1'b0;
                end
                HOLD: begin
                    // Released in the transfer cycle so EX retires the multiply
                    // and IDLE does not see the same instruction again.
                    stall_s = mem_stall;
                end
                DRAIN: begin
                    // A new multiply must wait for the abandoned one to finish
                    stall_s = is_mul_s;
                end
                default: begin
                    start_s = 1'b0;
                    stall_s = 1'b0;
                end
            endcase
        end
    end

    assign startM     = start_s;
    assign stall_mext = stall_s;
    assign mul_opcode = start_s ? 2'(dec_op_s) : 2'b00;
    assign operand1   = start_s ? ex_rs1 : 32'h0000_0000;
    assign operand2   = start_s ? ex_rs2 : 32'h0000_0000;

    // Issue/complete FSM with result capture, watchdog and error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            wdog_cnt_r <= '0;
            rd_lat_r   <= 5'd0;
            result_r   <= 32'h0000_0000;
            rd_r       <= 5'd0;
            valid_r    <= 1'b0;
            illegal_r  <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            illegal_r <= is_div_s && !flush;
            case (state_r)
                IDLE: begin
                    valid_r <= 1'b0;
                    if (start_s) begin
                        rd_lat_r   <= ex_rd;
                        wdog_cnt_r <= CNT_ONE;
                        state_r    <= BUSY;
                    end else begin
                        wdog_cnt_r <= '0;
                        state_r    <= IDLE;
                    end
                end
                BUSY: begin
                    if (flush && done) begin
                        // Flush wins; the multiplier has already finished
                        state_r <= IDLE;
                    end else if (flush) begin
                        wdog_cnt_r <= wdog_inc_s;
                        state_r    <= DRAIN;
                    end else if (done) begin
                        result_r <= result_multiply;
                        rd_r     <= rd_lat_r;
                        valid_r  <= 1'b1;
                        state_r  <= mem_stall ? HOLD : OUT;
                    end else if (wdog_hit_s) begin
                        timeout_r <= 1'b1;
                        state_r   <= IDLE;
                    end else begin
                        wdog_cnt_r <= wdog_inc_s;
                        state_r    <= BUSY;
                    end
                end
                OUT: begin
                    valid_r <= 1'b0;
                    state_r <= IDLE;
                end
                HOLD: begin
                    if (!mem_stall) begin
                        valid_r <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        valid_r <= 1'b1;
                        state_r <= HOLD;
                    end
                end
                DRAIN: begin
                    if (done) begin
                        state_r <= IDLE;
                    end else if (wdog_hit_s) begin
                        timeout_r <= 1'b1;
                        state_r   <= IDLE;
                    end else begin
                        wdog_cnt_r <= wdog_inc_s;
                        state_r    <= DRAIN;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign mext_valid   = valid_r;
    assign mext_result  = result_r;
    assign mext_rd      = rd_r;
    assign mext_illegal = illegal_r;
    assign mext_timeout = timeout_r;

endmodule

// File: tb/tb_mext_issue_ctrl.sv
// Scoreboard bench for mext_issue_ctrl with a behavioural multiplier model.
module tb_mext_issue_ctrl;

    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic [31:0] ex_rs1, ex_rs2;
    logic [4:0]  ex_rd;
    logic        flush, mem_stall;
    logic        startM;
    logic [1:0]  mul_opcode;
    logic [31:0] operand1, operand2;
    logic [31:0] result_multiply;
    logic        done;
    logic        stall_mext, mext_valid;
    logic [31:0] mext_result;
    logic [4:0]  mext_rd;
    logic        mext_illegal, mext_timeout;

    mext_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .flush(flush), .mem_stall(mem_stall), .startM(startM),
        .mul_opcode(mul_opcode), .operand1(operand1), .operand2(operand2),
        .result_multiply(result_multiply), .done(done), .stall_mext(stall_mext),
        .mext_valid(mext_valid), .mext_result(mext_result), .mext_rd(mext_rd),
        .mext_illegal(mext_illegal), .mext_timeout(mext_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          mdl_armed = 1'b0;
    bit          mdl_hang = 1'b0;
    int          mdl_lat = 34;
    int          mdl_due = 0;
    logic [31:0] mdl_res = 32'h0;
    int          valid_rise_cyc = -1;
    logic        prev_start = 1'b0;
    logic        prev_valid = 1'b0;

    // Architectural RV32M multiply result
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            2'b00:   begin p = ua * ub; return p[31:0];  end
            2'b01:   begin p = sa * sb; return p[63:32]; end
            2'b10:   begin p = sa * ub; return p[63:32]; end
            default: begin p = ua * ub; return p[63:32]; end
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Multiplier model output side: raises done mdl_lat cycles after start
    initial begin
        done = 1'b0;
        result_multiply = 32'h0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            if (mdl_armed && cyc == mdl_due) begin
                done = 1'b1;
                result_multiply = mdl_res;
                mdl_armed = 1'b0;
            end else begin
                done = 1'b0;
            end
        end
    end

    // Monitor: start-pulse legality, multiplier launch, scoreboard pops
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_start = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (startM) begin
                    checks++;
                    if (prev_start || mdl_armed) begin
                        errors++;
                        $display("FAIL start_legal: startM=1 with prev_start=%0d mul_busy=%0d", prev_start, mdl_armed);
                    end
                    if (!mdl_hang) begin
                        mdl_armed = 1'b1;
                        mdl_due   = cyc + mdl_lat;
                        mdl_res   = ref_mul(mul_opcode, operand1, operand2);
                    end
                end
                if (mext_valid && !prev_valid) valid_rise_cyc = cyc;
                if (mext_valid && !mem_stall) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: result 0x%08h rd %0d, expected no transfer", mext_result, mext_rd);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_result", mext_result, e.res);
                        chk("sb_rd", {27'h0, mext_rd}, {27'h0, e.rd});
                    end
                end
                prev_start = startM;
                prev_valid = mext_valid;
            end
        end
    end

    task automatic drive_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        ex_valid  = 1'b1;
        ex_opcode = 7'b0110011;
        ex_funct7 = 7'b0000001;
        ex_funct3 = {1'b0, op};
        ex_rs1    = a;
        ex_rs2    = b;
        ex_rd     = rd;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        ex_valid = 1'b0;
        flush = 1'b0;
        mem_stall = 1'b0;
        mdl_armed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_start(output int s);
        s = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (startM) begin
                s = cyc;
                break;
            end
        end
        checks++;
        if (s < 0) begin
            errors++;
            $display("FAIL start_seen: no startM within 100 cycles");
        end
    endtask

    // One multiply end to end; hold<0 means no MEM back-pressure, otherwise
    // mem_stall covers done and stays up for hold extra cycles.
    task automatic run_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input int lat, input int hold,
                           output int st, output int pres);
        exp_t e;
        int   n, stalls;
        bit   started, released;
        logic [31:0] want;
        want = ref_mul(op, a, b);
        e.rd = rd;
        e.res = want;
        exp_q.push_back(e);
        mdl_lat = lat;
        @(posedge clk); #1;
        drive_mul(op, a, b, rd);
        pres = cyc;
        st = -1;
        started = 1'b0;
        released = 1'b0;
        n = 0;
        stalls = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!started && startM) begin
                started = 1'b1;
                st = cyc;
                n = 0;
            end
            if (started && stall_mext) stalls++;
            if (mext_valid && mem_stall) chk("hold_result", mext_result, want);
            if (!stall_mext) begin
                released = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (started) n++;
            mem_stall = (hold >= 0) && started && (n >= 1) && (n <= lat + 1 + hold);
        end
        chk("issued", {31'h0, started}, 32'h1);
        chk("released", {31'h0, released}, 32'h1);
        if (hold < 0) chk("stall_cycles", stalls, lat + 1);
        else          chk("stall_cycles_hold", stalls, lat + hold + 2);
        chk("valid_latency", valid_rise_cyc - st, lat + 1);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        mem_stall = 1'b0;
    endtask

    initial begin
        int s, st, pres, lat, hold;
        bit early;
        logic [31:0] a, b;
        logic [31:0] corner [4];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'h7FFF_FFFF;
        rst = 1'b1;
        ex_valid = 1'b0; ex_opcode = 7'h0; ex_funct3 = 3'h0; ex_funct7 = 7'h0;
        ex_rs1 = 32'h0; ex_rs2 = 32'h0; ex_rd = 5'h0; flush = 1'b0; mem_stall = 1'b0;
        do_reset();
        @(negedge clk);
        chk("reset_ctrl", {26'h0, startM, stall_mext, mext_valid, mext_illegal, mext_timeout, 1'b0}, 32'h0);
        chk("reset_opcode", {30'h0, mul_opcode}, 32'h0);
        chk("reset_op1", operand1, 32'h0);
        chk("reset_op2", operand2, 32'h0);
        chk("reset_result", mext_result, 32'h0);
        chk("reset_rd", {27'h0, mext_rd}, 32'h0);

        // MUL 7 x -3 -> rd 5
        run_mul(2'b00, 32'd7, 32'hFFFF_FFFD, 5'd5, 34, -1, st, pres);
        chk("mul_result", mext_result, 32'hFFFF_FFEB);
        chk("mul_rd", {27'h0, mext_rd}, 32'd5);

        // MULHU max x max with back-pressure around done
        run_mul(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 34, 2, st, pres);
        chk("mulhu_result", mext_result, 32'hFFFF_FFFE);

        // Flush during BUSY, next MUL presented while draining
        mdl_lat = 34;
        @(posedge clk); #1;
        drive_mul(2'b00, 32'd11, 32'd13, 5'd9);
        wait_start(s);
        repeat (10) @(posedge clk);
        #1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        ex_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("drain_no_stall", {31'h0, stall_mext}, 32'h0);
        repeat (2) @(posedge clk);
        run_mul(2'b01, 32'h8000_0000, 32'd3, 5'd12, 34, -1, st, pres);
        chk("drain_restart_cycle", st - s, 35);

        // Flush and done in the same BUSY cycle go straight to IDLE
        mdl_lat = 20;
        @(posedge clk); #1;
        drive_mul(2'b10, 32'hFFFF_FFFE, 32'd5, 5'd3);
        wait_start(s);
        repeat (20) @(posedge clk);
        #1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        ex_valid = 1'b0;
        run_mul(2'b00, 32'd100, 32'd200, 5'd4, 12, -1, st, pres);
        chk("flush_done_idle", st, pres);

        // Divide encoding is flagged, not issued
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_opcode = 7'b0110011; ex_funct7 = 7'b0000001; ex_funct3 = 3'b100;
        @(negedge clk);
        chk("div_no_start", {31'h0, startM}, 32'h0);
        chk("div_no_stall", {31'h0, stall_mext}, 32'h0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        chk("div_illegal", {31'h0, mext_illegal}, 32'h1);
        @(negedge clk);
        chk("div_illegal_pulse", {31'h0, mext_illegal}, 32'h0);

        // Hung multiplier trips the watchdog
        mdl_hang = 1'b1;
        @(posedge clk); #1;
        drive_mul(2'b00, 32'd5, 32'd6, 5'd3);
        wait_start(s);
        early = 1'b0;
        for (int k = 1; k < TIMEOUT; k++) begin
            @(negedge clk);
            if (mext_timeout) early = 1'b1;
        end
        chk("timeout_not_early", {31'h0, early}, 32'h0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        chk("timeout_cycle", cyc - s, TIMEOUT);
        chk("timeout_flag", {31'h0, mext_timeout}, 32'h1);
        chk("timeout_no_stall", {31'h0, stall_mext}, 32'h0);
        mdl_hang = 1'b0;
        run_mul(2'b00, 32'd9, 32'd9, 5'd1, 8, -1, st, pres);
        chk("timeout_idle_start", st, pres);
        chk("timeout_sticky", {31'h0, mext_timeout}, 32'h1);

        // Reset in the middle of an operation
        mdl_lat = 34;
        @(posedge clk); #1;
        drive_mul(2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 5'd30);
        wait_start(s);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        ex_valid = 1'b0;
        mdl_armed = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ctrl", {27'h0, startM, stall_mext, mext_valid, mext_illegal, mext_timeout}, 32'h0);
        chk("rst_mid_result", mext_result, 32'h0);
        chk("rst_mid_rd", {27'h0, mext_rd}, 32'h0);
        chk("rst_mid_ops", operand1 | operand2 | {30'h0, mul_opcode}, 32'h0);
        run_mul(2'b00, 32'd3, 32'd4, 5'd7, 34, -1, st, pres);
        chk("rst_then_mul", mext_result, 32'h0000_000C);

        // Randomised traffic with varying latency and back-pressure
        for (int i = 0; i < 12; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            lat = $urandom_range(2, 38);
            hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_mul(2'($urandom_range(0, 3)), a, b, 5'($urandom_range(0, 31)), lat, hold, st, pres);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound on the whole run
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/mext_issue_ctrl.md
# mext_issue_ctrl

EX-stage controller for RV32M multiply instructions in the 5-stage pipeline. It decodes R-type M-extension instructions, launches the iterative multiplier with a one-cycle start pulse, and stalls the front of the pipeline while the multiply runs. It captures the multiplier result on its done pulse and presents it, with the destination register, to the EX/MEM boundary. It also handles pipeline flushes and MEM back-pressure, and monitors the multiplier for a hung operation.

## Interface
- TIMEOUT, default 40: BUSY cycles allowed before `mext_timeout` is raised.
- clk  in  1  clock.
- rst  in  1  reset; synchronous and active-high (one clock, no other clock domains).
- ex_valid  in  1  EX holds a valid instruction.
- ex_opcode  in  7  instruction[6:0].
- ex_funct3  in  3  instruction[14:12].
- ex_funct7  in  7  instruction[31:25].
- ex_rs1, ex_rs2  in  32  forwarded operand values.
- ex_rd  in  5  destination register.
- flush  in  1  kill the in-flight EX instruction (branch/jump redirect).
- mem_stall  in  1  MEM cannot accept a result this cycle.
- startM  out  1  start pulse to the multiplier.
- mul_opcode  out  2  multiplier operation select.
- operand1, operand2  out  32  multiplier operands.
- result_multiply  in  32  multiplier result.
- done  in  1  one-cycle multiplier completion pulse.
- stall_mext  out  1  freeze IF/ID/EX.
- mext_valid  out  1  result valid toward MEM.
- mext_result  out  32  result toward MEM.
- mext_rd  out  5  destination register toward MEM.
- mext_illegal  out  1  one-cycle pulse for M-extension divide encodings (not supported).
- mext_timeout  out  1  sticky error flag; cleared only by rst.

## Operation
- An instruction is a multiply (`is_mul`) when ex_valid, ex_opcode=0110011, ex_funct7=0000001 and ex_funct3[2]=0.
  - mul_opcode = ex_funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- Divide encodings (same opcode/funct7, ex_funct3[2]=1): pulse `mext_illegal` for one cycle; no start, no stall.
- **IDLE**: on `is_mul` and !flush:
  - drive startM=1 for this cycle only, with operand1=ex_rs1, operand2=ex_rs2;
  - latch ex_rd;
  - go to BUSY.
  - stall_mext is asserted combinationally in this same cycle.
- **BUSY**: stall_mext=1; the watchdog counter increments each cycle.
  - On done: capture result_multiply. If mem_stall, go to HOLD; otherwise go to OUT.
  - On flush: go to DRAIN.
- **OUT**: mext_valid=1 for one cycle; stall_mext=0, so EX advances; go to IDLE.
- **HOLD**: mext_valid=1 with mext_result and mext_rd stable; stall_mext=1. When !mem_stall, go to IDLE; the transfer occurs in that cycle.
- **DRAIN**: the multiplier cannot abort, so wait for done and discard the result; then go to IDLE.
  - stall_mext=0 unless `is_mul` is asserted, in which case stall until IDLE is reached and the start is issued.
- If flush and done occur in the same BUSY cycle, flush wins: the result is discarded and the FSM returns to IDLE (not DRAIN).
- A done pulse received in IDLE, OUT or HOLD is ignored.
- Watchdog: if the counter reaches TIMEOUT in BUSY or DRAIN, set `mext_timeout` and force the FSM to IDLE. The counter clears on entry to BUSY.

## Timing
- Reset values:
  - all outputs 0, including operands and mext_result;
  - FSM in IDLE; counter 0; mext_timeout 0.
- Reset mid-operation returns the FSM to IDLE at once. The multiplier is reset by the same rst.
- startM is never asserted for more than one cycle, and never while in BUSY or DRAIN.
- Nominal multiplier latency: done arrives 34 cycles after the startM cycle, so mext_valid is high at start+35. Correctness must not depend on the exact latency.
- mext_result and mext_rd are registered and hold their value until the next capture.

## Structure
- Shared package `mext_pkg`:
  - mul_op_t enum (MUL/MULH/MULHSU/MULHU = 00..11);
  - OPC_OP = 7'b0110011, F7_MEXT = 7'b0000001;
  - FSM state enum (IDLE, BUSY, OUT, HOLD, DRAIN).
- One natural sub-module: `mext_decode`, the combinational classifier producing is_mul, is_div and mul_opcode.
- The FSM, the result register and the watchdog all live in the top module.

## Test plan
- MUL with rs1=7, rs2=0xFFFFFFFD (-3), rd=5 → one startM pulse with mul_opcode=00 → mext_valid=1 at start+35, mext_result=0xFFFFFFEB, mext_rd=5; stall_mext high for cycles start..start+34.
- MULHU with 0xFFFFFFFF × 0xFFFFFFFF and mem_stall held for 3 cycles around done → HOLD keeps mext_valid=1 and mext_result=0xFFFFFFFE stable until mem_stall drops; exactly one transfer.
- MUL issued, flush asserted 10 cycles after start, then a new MUL is presented 5 cycles later → no mext_valid for the first op; the second startM is issued only after the first done; its result is correct.
- DIV encoding (funct3=100) → mext_illegal single pulse, startM=0, stall_mext=0.
- Multiplier model with done tied low, TIMEOUT=40 → mext_timeout rises 40 cycles after start, the FSM is back in IDLE, and the flag stays high until rst.
- rst asserted at start+20 → all outputs 0 on the next cycle; a following MUL 3×4 yields 0x0000000C.
